// File: rtl/encoder16x4_seq.sv
// Sequential priority encoder: drains a captured request vector,
// emitting set-bit indices highest first over valid/ready.
module encoder16x4_seq #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [IN_W-1:0]  w,
    output logic [OUT_W-1:0] y,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done,
    output logic [OUT_W:0]   left
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]      state;
    logic [IN_W-1:0] pend;
    logic [IN_W-1:0] pend_clr;
    logic            done_q;

    // Later iterations win, so y ends on the most significant set bit.
    always_comb begin
        y = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (pend[i]) y = OUT_W'(i);
        end
    end

    always_comb begin
        left = '0;
        for (int i = 0; i < IN_W; i++) begin
            left = left + (OUT_W+1)'(pend[i]);
        end
    end

    assign pend_clr = pend & ~({{(IN_W-1){1'b0}}, 1'b1} << y);
    assign busy     = (state == SCAN);
    assign valid    = busy && en;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                unique case (state)
                    IDLE: begin
                        if (load) begin
                            if (w != '0) begin
                                pend  <= w;
                                state <= SCAN;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (ready) begin
                            pend <= pend_clr;
                            if (pend_clr == '0) begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_encoder16x4_seq.sv
// Directed bench for encoder16x4_seq: table-driven drains
// plus hand-written multi-cycle sequences.
module tb_encoder16x4_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] w;
    logic [3:0]  y;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic [4:0]  left;

    int checks = 0;
    int failures = 0;

    encoder16x4_seq dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .w     (w),
        .y     (y),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .left  (left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int          first_y;
        int          k;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int exp_y;
        int emitted;
        int cnt;

        tbl[0] = '{16'h0001, 0, 1};
        tbl[1] = '{16'h8000, 15, 1};
        tbl[2] = '{16'h1234, 12, 5};
        tbl[3] = '{16'hA5A5, 15, 8};
        tbl[4] = '{16'h0F00, 11, 4};
        tbl[5] = '{16'h7FFE, 14, 14};

        // 1: reset
        rst = 1'b1; en = 1'b0; load = 1'b0; w = '0; ready = 1'b1;
        tick(); tick();
        check("rst_y", y, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_left", left, 0);
        rst = 1'b0;
        tick();

        // 2: 8421 drain with ready held
        en = 1'b1; load = 1'b1; w = 16'h8421;
        tick();
        load = 1'b0;
        check("t2_valid", valid, 1);
        check("t2_busy", busy, 1);
        check("t2_y0", y, 15); check("t2_l0", left, 4);
        tick();
        check("t2_y1", y, 10); check("t2_l1", left, 3);
        tick();
        check("t2_y2", y, 5); check("t2_l2", left, 2);
        tick();
        check("t2_y3", y, 0); check("t2_l3", left, 1);
        tick();
        check("t2_done", done, 1);
        check("t2_valid_end", valid, 0);
        check("t2_left_end", left, 0);
        tick();
        check("t2_done_pulse", done, 0);

        // 3: empty load
        load = 1'b1; w = 16'h0000;
        tick();
        load = 1'b0;
        check("t3_valid", valid, 0);
        check("t3_busy", busy, 0);
        check("t3_done", done, 1);
        tick();
        check("t3_done_pulse", done, 0);
        check("t3_busy2", busy, 0);

        // 4: FFFF with ready pattern 1,0,0,1
        load = 1'b1; w = 16'hFFFF;
        tick();
        load = 1'b0;
        exp_y = 15;
        emitted = 0;
        for (int c = 0; emitted < 16 && c < 100; c++) begin
            ready = (c % 4 == 0) || (c % 4 == 3);
            check("t4_valid", valid, 1);
            check("t4_y", y, exp_y);
            check("t4_left", left, 16 - emitted);
            tick();
            if (ready) begin
                emitted++;
                exp_y--;
            end
        end
        check("t4_count", emitted, 16);
        check("t4_done", done, 1);
        check("t4_valid_end", valid, 0);
        ready = 1'b1;
        tick();

        // 5: en drop mid-scan, load ignored
        load = 1'b1; w = 16'h0300; ready = 1'b0;
        tick();
        load = 1'b0;
        check("t5_y_first", y, 9);
        check("t5_valid_first", valid, 1);
        en = 1'b0; ready = 1'b1; load = 1'b1; w = 16'h0001;
        #1;
        check("t5_valid_en0", valid, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_valid_frozen", valid, 0);
            check("t5_y_frozen", y, 9);
            check("t5_left_frozen", left, 2);
        end
        en = 1'b1;
        #1;
        check("t5_valid_resume", valid, 1);
        check("t5_y_resume", y, 9);
        tick();
        load = 1'b0;
        check("t5_y_next", y, 8);
        check("t5_left_next", left, 1);
        tick();
        check("t5_done", done, 1);
        check("t5_left_end", left, 0);
        check("t5_busy_end", busy, 0);
        tick();

        // 6: reset aborts a scan
        load = 1'b1; w = 16'h00F0;
        tick();
        load = 1'b0;
        check("t6_y7", y, 7);
        tick();
        check("t6_y6", y, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_y", y, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_left", left, 0);
        check("t6_rst_done", done, 0);
        tick();
        check("t6_no_done", done, 0);
        load = 1'b1; w = 16'h0002;
        tick();
        load = 1'b0;
        check("t6_fresh_y", y, 1);
        check("t6_fresh_valid", valid, 1);
        tick();
        check("t6_fresh_done", done, 1);

        // table: loads land in the done cycle of the previous drain
        for (int i = 0; i < 6; i++) begin
            load = 1'b1; w = tbl[i].w;
            tick();
            load = 1'b0;
            check("tbl_first_y", y, tbl[i].first_y);
            check("tbl_left", left, tbl[i].k);
            cnt = 0;
            for (int c = 0; valid && c < 20; c++) begin
                check("tbl_left_step", left, tbl[i].k - cnt);
                cnt++;
                tick();
            end
            check("tbl_transfers", cnt, tbl[i].k);
            check("tbl_done", done, 1);
        end
        tick();
        check("tbl_done_pulse", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
